vcd_change_scheduler: RTL and testbench

Sequences 4-state value-change dumping for a fixed set of watched signals. At each timestep boundary it snapshots all signals and compares them, both planes, against the last dumped values. It then streams a timestamp record followed by one value record per changed signal, in ascending index order, over a single valid/ready port. It sits between the simulated design's watched nets and the VCD text formatter, and serializes N signals onto one formatter.

---
 rtl/vcd_change_scheduler.sv | 178 +++++++++++++++++
 tb/tb_vcd_change_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vcd_change_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : vcd_change_scheduler
// Description : Snapshots watched 4-state signals at each timestep and streams
//               a timestamp record plus one record per changed signal.
// Revision    : 1.0 - initial release
// ============================================================================
module vcd_change_scheduler #(
    parameter int NUM_SIG = 4,
    parameter int WIDTH   = 4,
    parameter int TIME_W  = 32,
    parameter int IDX_W   = (NUM_SIG > 1) ? $clog2(NUM_SIG) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample,
    input  logic [TIME_W-1:0]        time_in,
    input  logic [NUM_SIG*WIDTH-1:0] sig_val,
    input  logic [NUM_SIG*WIDTH-1:0] sig_xz,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic                     rec_type,
    output logic [IDX_W-1:0]         rec_idx,
    output logic [TIME_W-1:0]        rec_time,
    output logic [WIDTH-1:0]         rec_val,
    output logic [WIDTH-1:0]         rec_xz,
    output logic                     busy,
    output logic                     sample_dropped
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TIME  = 2'd1,
        S_VALUE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0]   r_shadow_val [NUM_SIG];
    logic [WIDTH-1:0]   r_shadow_xz  [NUM_SIG];
    logic [WIDTH-1:0]   r_snap_val   [NUM_SIG];
    logic [WIDTH-1:0]   r_snap_xz    [NUM_SIG];
    logic               r_shadow_valid;
    logic [NUM_SIG-1:0] r_mask;

    logic [NUM_SIG-1:0] w_live_mask;
    logic [NUM_SIG-1:0] w_rem_mask;
    logic [NUM_SIG-1:0] w_scan_mask;
    logic [IDX_W-1:0]   w_scan_idx;
    logic               w_scan_any;
    logic               w_hs;
    logic               w_accept;
    logic               w_load_val;
    logic               w_retire;
    logic               w_finish;
    logic               w_drop;

    assign w_hs   = rec_valid & rec_ready;
    assign busy   = (r_state != S_IDLE);
    assign w_drop = sample & busy;

    // Change detection over both planes; an invalid shadow forces a full dump.
    for (genvar gi = 0; gi < NUM_SIG; gi++) begin : g_sig
        assign w_live_mask[gi] = !r_shadow_valid
                              || (sig_val[gi*WIDTH +: WIDTH] != r_shadow_val[gi])
                              || (sig_xz[gi*WIDTH +: WIDTH]  != r_shadow_xz[gi]);
        assign w_rem_mask[gi]  = r_mask[gi] && (rec_idx != IDX_W'(gi));
    end

    assign w_scan_mask = (r_state == S_TIME) ? r_mask : w_rem_mask;

    always_comb begin
        w_scan_idx = '0;
        w_scan_any = 1'b0;
        for (int i = NUM_SIG - 1; i >= 0; i--) begin
            if (w_scan_mask[i]) begin
                w_scan_idx = IDX_W'(i);
                w_scan_any = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_load_val   = 1'b0;
        w_retire     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sample && (|w_live_mask)) begin
                    w_state_next = S_TIME;
                    w_accept     = 1'b1;
                end
            end
            S_TIME: begin
                if (w_hs) begin
                    w_state_next = S_VALUE;
                    w_load_val   = 1'b1;
                end
            end
            S_VALUE: begin
                if (w_hs) begin
                    w_retire = 1'b1;
                    if (w_scan_any) begin
                        w_load_val = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                        w_finish     = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rec_valid      <= 1'b0;
            rec_type       <= 1'b0;
            rec_idx        <= '0;
            rec_time       <= '0;
            rec_val        <= '0;
            rec_xz         <= '0;
            sample_dropped <= 1'b0;
            r_shadow_valid <= 1'b0;
            r_mask         <= '0;
        end else begin
            sample_dropped <= w_drop;
            if (w_accept) begin
                r_mask    <= w_live_mask;
                rec_valid <= 1'b1;
                rec_type  <= 1'b0;
                rec_idx   <= '0;
                rec_time  <= time_in;
                rec_val   <= '0;
                rec_xz    <= '0;
            end
            if (w_retire) r_mask <= w_rem_mask;
            if (w_load_val) begin
                rec_type <= 1'b1;
                rec_idx  <= w_scan_idx;
                rec_val  <= r_snap_val[w_scan_idx];
                rec_xz   <= r_snap_xz[w_scan_idx];
            end
            if (w_finish) begin
                rec_valid      <= 1'b0;
                rec_type       <= 1'b0;
                rec_idx        <= '0;
                rec_val        <= '0;
                rec_xz         <= '0;
                r_shadow_valid <= 1'b1;
            end
        end
    end

    // Snapshot and shadow contents are qualified by r_shadow_valid, so no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < NUM_SIG; i++) begin
                r_snap_val[i] <= sig_val[i*WIDTH +: WIDTH];
                r_snap_xz[i]  <= sig_xz[i*WIDTH +: WIDTH];
            end
        end
        if (w_retire) begin
            r_shadow_val[rec_idx] <= r_snap_val[rec_idx];
            r_shadow_xz[rec_idx]  <= r_snap_xz[rec_idx];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vcd_change_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_vcd_change_scheduler
// Description : Directed plus random stimulus against a record-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vcd_change_scheduler;

    localparam int NUM_SIG = 4;
    localparam int WIDTH   = 4;
    localparam int TIME_W  = 32;
    localparam int IDX_W   = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     sample;
    logic [TIME_W-1:0]        time_in;
    logic [NUM_SIG*WIDTH-1:0] sig_val;
    logic [NUM_SIG*WIDTH-1:0] sig_xz;
    logic                     rec_valid;
    logic                     rec_ready;
    logic                     rec_type;
    logic [IDX_W-1:0]         rec_idx;
    logic [TIME_W-1:0]        rec_time;
    logic [WIDTH-1:0]         rec_val;
    logic [WIDTH-1:0]         rec_xz;
    logic                     busy;
    logic                     sample_dropped;

    vcd_change_scheduler #(
        .NUM_SIG(NUM_SIG), .WIDTH(WIDTH), .TIME_W(TIME_W), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .sample(sample), .time_in(time_in),
        .sig_val(sig_val), .sig_xz(sig_xz),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_type(rec_type),
        .rec_idx(rec_idx), .rec_time(rec_time), .rec_val(rec_val),
        .rec_xz(rec_xz), .busy(busy), .sample_dropped(sample_dropped)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              typ;
        logic [IDX_W-1:0]  idx;
        logic [TIME_W-1:0] tm;
        logic [WIDTH-1:0]  v;
        logic [WIDTH-1:0]  x;
    } rec_t;

    rec_t             q[$];
    logic [WIDTH-1:0] sh_v [NUM_SIG];
    logic [WIDTH-1:0] sh_x [NUM_SIG];
    bit               sh_ok     = 1'b0;
    bit               exp_drop  = 1'b0;
    bit               after_rst = 1'b1;
    int               total     = 0;
    int               bad       = 0;

    logic [NUM_SIG*WIDTH-1:0] cur_v;
    logic [NUM_SIG*WIDTH-1:0] cur_x;
    logic [TIME_W-1:0]        t_now;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle: check outputs against the model, drive inputs, advance the model.
    task automatic step(input bit r, input bit s, input logic [TIME_W-1:0] t,
                        input logic [NUM_SIG*WIDTH-1:0] v, input logic [NUM_SIG*WIDTH-1:0] x,
                        input bit rdy);
        rec_t h;
        rec_t ch[$];
        bit   was_busy;
        @(negedge clk);
        check_val("rec_valid", rec_valid, q.size() != 0);
        check_val("busy", busy, q.size() != 0);
        check_val("sample_dropped", sample_dropped, exp_drop);
        if (q.size() != 0) begin
            check_val("rec_type", rec_type, q[0].typ);
            check_val("rec_idx", rec_idx, q[0].idx);
            check_val("rec_time", rec_time, q[0].tm);
            check_val("rec_val", rec_val, q[0].v);
            check_val("rec_xz", rec_xz, q[0].x);
        end else if (after_rst) begin
            check_val("rst_rec", {rec_type, rec_idx, rec_time, rec_val, rec_xz}, 0);
        end

        rst = r; sample = s; time_in = t; sig_val = v; sig_xz = x; rec_ready = rdy;

        if (r) begin
            q.delete();
            sh_ok     = 1'b0;
            exp_drop  = 1'b0;
            after_rst = 1'b1;
        end else begin
            was_busy = (q.size() != 0);
            exp_drop = s && was_busy;
            if (was_busy && rdy) begin
                h = q.pop_front();
                if (h.typ) begin
                    sh_v[h.idx] = h.v;
                    sh_x[h.idx] = h.x;
                    if (q.size() == 0) sh_ok = 1'b1;
                end
            end
            if (!was_busy && s) begin
                for (int i = 0; i < NUM_SIG; i++) begin
                    if (!sh_ok || v[i*WIDTH +: WIDTH] != sh_v[i] || x[i*WIDTH +: WIDTH] != sh_x[i])
                        ch.push_back('{1'b1, IDX_W'(i), t, v[i*WIDTH +: WIDTH], x[i*WIDTH +: WIDTH]});
                end
                if (ch.size() != 0) begin
                    q.push_back('{1'b0, '0, t, '0, '0});
                    foreach (ch[k]) q.push_back(ch[k]);
                    after_rst = 1'b0;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, t_now, cur_v, cur_x, 1'b1);
    endtask

    initial begin
        rst = 1'b1; sample = 1'b0; time_in = '0; sig_val = '0; sig_xz = '0; rec_ready = 1'b0;
        cur_v = '0; cur_x = '0; t_now = '0;
        step(1'b1, 1'b0, 0, cur_v, cur_x, 1'b0);
        step(1'b1, 1'b0, 0, cur_v, cur_x, 1'b0);

        // Initial full dump: xxxx, zzzz, 10xz, 0000
        cur_v = {4'h0, 4'hA, 4'h0, 4'hF};
        cur_x = {4'h0, 4'h3, 4'hF, 4'hF};
        step(1'b0, 1'b1, 0, cur_v, cur_x, 1'b1);
        idle(7);

        // Identical inputs: nothing emitted
        step(1'b0, 1'b1, 1, cur_v, cur_x, 1'b1);
        idle(3);

        // x -> z on signal 0 only
        cur_v[3:0] = 4'h0;
        step(1'b0, 1'b1, 2, cur_v, cur_x, 1'b1);
        idle(4);

        // Three changes with backpressure on the second record
        cur_v[15:4] = {4'hF, 4'h0, 4'h5};
        cur_x[15:4] = {4'h1, 4'h0, 4'h0};
        step(1'b0, 1'b1, 3, cur_v, cur_x, 1'b1);
        step(1'b0, 1'b0, 3, cur_v, cur_x, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3, cur_v, cur_x, 1'b0);
        idle(5);

        // Sample while busy is dropped
        cur_v[3:0] = 4'h6;
        step(1'b0, 1'b1, 4, cur_v, cur_x, 1'b1);
        step(1'b0, 1'b1, 99, cur_v, cur_x, 1'b0);
        step(1'b0, 1'b0, 4, cur_v, cur_x, 1'b0);
        idle(4);

        // Reset during VALUE, then full dump of unchanged inputs
        cur_v[7:0] = 8'h93;
        step(1'b0, 1'b1, 5, cur_v, cur_x, 1'b1);
        step(1'b0, 1'b0, 5, cur_v, cur_x, 1'b1);
        step(1'b1, 1'b0, 5, cur_v, cur_x, 1'b0);
        step(1'b0, 1'b0, 6, cur_v, cur_x, 1'b1);
        step(1'b0, 1'b1, 6, cur_v, cur_x, 1'b1);
        idle(7);

        t_now = 7;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                int s_i;
                s_i = $urandom_range(0, NUM_SIG - 1);
                cur_v[s_i*WIDTH +: WIDTH] = WIDTH'($urandom);
                cur_x[s_i*WIDTH +: WIDTH] = ($urandom_range(0, 1) == 0) ? '0 : WIDTH'($urandom);
            end
            t_now = t_now + TIME_W'($urandom_range(0, 3));
            step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, t_now,
                 cur_v, cur_x, $urandom_range(0, 3) != 0);
        end
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
